// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the parameterised UART receiver.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Receiver frame-tracking states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

   // Parity mode encodings for PARITY_MODE
   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler
// Brief    : Two-flop synchronizer for the serial line plus a 3-tap majority
//            vote over the three most recent synchronized samples.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sampler (
   input  logic rxclk,
   input  logic rxrst,
   input  logic i_rx,
   output logic o_rx_sync,
   output logic o_maj
);

   logic [1:0] sync_q, sync_d;
   logic [1:0] hist_q, hist_d;

   // Next values: synchronizer chain and history of synchronized samples
   always_comb begin
      sync_d = {sync_q[0], i_rx};
      hist_d = {hist_q[0], sync_q[1]};
   end

   // Registers reset to the idle-high line level
   always_ff @(posedge rxclk) begin
      if (rxrst) begin
         sync_q <= 2'b11;
         hist_q <= 2'b11;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign o_rx_sync = sync_q[1];
   // Majority of the current sample and the two before it
   assign o_maj = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parameterised UART receiver: majority-voted bit sampling,
//            optional parity, one or two stop bits, held output with
//            valid/ready handshake and sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1085,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 rxclk,
   input  logic                 rxrst,
   input  logic                 rxclken,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] dout,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 rx_busy
);

   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam int BW = $clog2(DATA_BITS + 1);
   // The majority window spans centre-1..centre+1, so the decision is taken
   // on the cycle holding the centre+1 sample.
   localparam logic [CW-1:0] c_start_decide = CW'((CLKS_PER_BIT - 1) / 2 + 1);
   localparam logic [CW-1:0] c_bit_last     = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] c_data_last    = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] c_stop_last    = BW'(STOP_BITS - 1);
   localparam logic          c_odd          = (PARITY_MODE == PARITY_ODD);

   rx_state_e              state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [BW-1:0]          bitpos_q, bitpos_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic [DATA_BITS-1:0]   dout_q, dout_d;
   logic                   valid_q, valid_d;
   logic                   perr_out_q, perr_out_d;
   logic                   ferr_out_q, ferr_out_d;
   logic                   ovr_q, ovr_d;
   logic                   w_rx_sync;
   logic                   w_maj;
   logic                   w_done;

   uart_rx_sampler u_sampler (
      .rxclk     (rxclk),
      .rxrst     (rxrst),
      .i_rx      (rx),
      .o_rx_sync (w_rx_sync),
      .o_maj     (w_maj)
   );

   // Frame FSM: next state, bit timing counter and data/flag accumulation
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CW'(1);
      bitpos_d = bitpos_q;
      shift_d  = shift_q;
      perr_d   = perr_q;
      ferr_d   = ferr_q;
      w_done   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d    = '0;
            bitpos_d = '0;
            perr_d   = 1'b0;
            ferr_d   = 1'b0;
            if (rxclken && !w_rx_sync) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == c_start_decide) begin
               cnt_d   = '0;
               state_d = w_maj ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_q == c_bit_last) begin
               cnt_d   = '0;
               // LSB arrives first, so shifting in at the top leaves it at bit 0
               shift_d = {w_maj, shift_q[DATA_BITS-1:1]};
               if (bitpos_q == c_data_last) begin
                  bitpos_d = '0;
                  state_d  = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
               end else begin
                  bitpos_d = bitpos_q + BW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (cnt_q == c_bit_last) begin
               cnt_d   = '0;
               perr_d  = w_maj ^ (^shift_q) ^ c_odd;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt_q == c_bit_last) begin
               cnt_d  = '0;
               ferr_d = ferr_q | ~w_maj;
               if (bitpos_q == c_stop_last) begin
                  bitpos_d = '0;
                  w_done   = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  bitpos_d = bitpos_q + BW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Losing the enable abandons the frame in progress
      if (!rxclken && state_q != ST_IDLE) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         bitpos_d = '0;
         w_done   = 1'b0;
      end
   end

   // Output holding register with handshake and overrun detection
   always_comb begin
      dout_d     = dout_q;
      valid_d    = valid_q;
      perr_out_d = perr_out_q;
      ferr_out_d = ferr_out_q;
      ovr_d      = ovr_q;
      if (w_done) begin
         if (!valid_q || dout_ready) begin
            dout_d     = shift_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_d;
            valid_d    = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && dout_ready) begin
         valid_d = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge rxclk) begin
      if (rxrst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bitpos_q   <= '0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         dout_q     <= '0;
         valid_q    <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bitpos_q   <= bitpos_d;
         shift_q    <= shift_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         dout_q     <= dout_d;
         valid_q    <= valid_d;
         perr_out_q <= perr_out_d;
         ferr_out_q <= ferr_out_d;
         ovr_q      <= ovr_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign parity_err = perr_out_q;
   assign frame_err  = ferr_out_q;
   assign overrun    = ovr_q;
   assign rx_busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Brief    : Self-checking bench for uart_rx_param: three configurations
//            (8N1, 7E1, 8N2) at 16 clocks per bit, expected words from a
//            frame-level model, plus literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

   localparam int CPB = 16;
   localparam int NB [3] = '{8, 7, 8};
   localparam int PM [3] = '{0, 1, 0};
   localparam int NS [3] = '{1, 1, 2};

   typedef struct {
      int         u;
      logic [8:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       rx_a  [3];
   logic       rdy_a [3];
   logic       v_a   [3];
   logic       pe_a  [3];
   logic       fe_a  [3];
   logic       ov_a  [3];
   logic       bz_a  [3];
   logic [7:0] d0;
   logic [6:0] d1;
   logic [7:0] d2;

   exp_t expq[$];
   int   nchk = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
      .rxclk(clk), .rxrst(rst), .rxclken(en), .rx(rx_a[0]), .dout(d0), .dout_valid(v_a[0]),
      .dout_ready(rdy_a[0]), .parity_err(pe_a[0]), .frame_err(fe_a[0]), .overrun(ov_a[0]),
      .rx_busy(bz_a[0]));
   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
      .rxclk(clk), .rxrst(rst), .rxclken(en), .rx(rx_a[1]), .dout(d1), .dout_valid(v_a[1]),
      .dout_ready(rdy_a[1]), .parity_err(pe_a[1]), .frame_err(fe_a[1]), .overrun(ov_a[1]),
      .rx_busy(bz_a[1]));
   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u2 (
      .rxclk(clk), .rxrst(rst), .rxclken(en), .rx(rx_a[2]), .dout(d2), .dout_valid(v_a[2]),
      .dout_ready(rdy_a[2]), .parity_err(pe_a[2]), .frame_err(fe_a[2]), .overrun(ov_a[2]),
      .rx_busy(bz_a[2]));

   function automatic logic [8:0] dout_x(int u);
      case (u)
         0:       return {1'b0, d0};
         1:       return {2'b00, d1};
         default: return {1'b0, d2};
      endcase
   endfunction

   // Frame-level model: word masked to the configured width, parity verdict
   // from the XOR of the data bits, frame error if any checked stop bit is low.
   function automatic exp_t model(int u, logic [8:0] data, logic pbit, logic s1, logic s2);
      exp_t       e;
      logic [8:0] m;
      m = data & ((9'd1 << NB[u]) - 9'd1);
      e.u  = u;
      e.d  = m;
      e.pe = (PM[u] != 0) && (pbit != ((^m) ^ (PM[u] == 2)));
      e.fe = !s1 || (NS[u] == 2 && !s2);
      return e;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one serial frame on instance u's line, one bit per CPB clocks
   task automatic send(int u, logic [8:0] data, logic pbit, logic s1, logic s2);
      rx_a[u] = 1'b0;
      tick(CPB);
      for (int i = 0; i < NB[u]; i++) begin
         rx_a[u] = data[i];
         tick(CPB);
      end
      if (PM[u] != 0) begin
         rx_a[u] = pbit;
         tick(CPB);
      end
      rx_a[u] = s1;
      tick(CPB);
      if (NS[u] == 2) begin
         rx_a[u] = s2;
         tick(CPB);
      end
      rx_a[u] = 1'b1;
   endtask

   // Bounded wait for dout_valid; on success checks the literal values and,
   // with ready high, that valid lasts exactly one cycle
   task automatic expect_word(int u, logic [8:0] d, logic pe, logic fe);
      int found = 0;
      for (int i = 0; i < 400 && found == 0; i++) begin
         @(negedge clk);
         if (v_a[u]) found = 1;
      end
      chk($sformatf("valid_seen_u%0d", u), found, 1);
      if (found == 1) begin
         chk($sformatf("dout_u%0d", u), dout_x(u), d);
         chk($sformatf("parity_err_u%0d", u), pe_a[u], pe);
         chk($sformatf("frame_err_u%0d", u), fe_a[u], fe);
         if (rdy_a[u]) begin
            @(negedge clk);
            chk($sformatf("valid_one_cycle_u%0d", u), v_a[u], 0);
         end
      end
   endtask

   // Every cycle a word is held, it must match the model's oldest outstanding word
   always @(negedge clk) begin
      if (!rst) begin
         for (int u = 0; u < 3; u++) begin
            if (v_a[u]) begin
               nchk++;
               if (expq.size() == 0 || expq[0].u != u) begin
                  nerr++;
                  $display("FAIL held_word_u%0d: got dout=%0h with no word expected", u, dout_x(u));
               end else if (dout_x(u) !== expq[0].d || pe_a[u] !== expq[0].pe || fe_a[u] !== expq[0].fe) begin
                  nerr++;
                  $display("FAIL held_word_u%0d: got dout=%0h pe=%0b fe=%0b expected dout=%0h pe=%0b fe=%0b",
                           u, dout_x(u), pe_a[u], fe_a[u], expq[0].d, expq[0].pe, expq[0].fe);
               end
               if (rdy_a[u] && expq.size() > 0 && expq[0].u == u) void'(expq.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   ok;
      rst = 1'b1;
      en  = 1'b1;
      for (int u = 0; u < 3; u++) begin
         rx_a[u]  = 1'b1;
         rdy_a[u] = 1'b1;
      end
      tick(5);
      for (int u = 0; u < 3; u++)
         chk($sformatf("reset_outputs_u%0d", u),
             {dout_x(u), v_a[u], pe_a[u], fe_a[u], ov_a[u], bz_a[u]}, 0);
      rst = 1'b0;
      tick(5);

      // Pin the model against hand-worked values
      e = model(1, 9'h41, 1'b1, 1'b1, 1'b1);
      chk("model_pin_7e1_bad_parity", {e.d, e.pe, e.fe}, {9'h41, 1'b1, 1'b0});
      e = model(2, 9'h3C, 1'b0, 1'b1, 1'b0);
      chk("model_pin_8n2_stop2_low", {e.d, e.pe, e.fe}, {9'h3C, 1'b0, 1'b1});

      // 8N1 byte 0xA5
      expq.push_back(model(0, 9'hA5, 1'b0, 1'b1, 1'b1));
      fork
         send(0, 9'hA5, 1'b0, 1'b1, 1'b1);
         expect_word(0, 9'hA5, 1'b0, 1'b0);
      join
      tick(10);

      // 7E1: 0x41 with wrong parity bit, then correct parity
      expq.push_back(model(1, 9'h41, 1'b1, 1'b1, 1'b1));
      fork
         send(1, 9'h41, 1'b1, 1'b1, 1'b1);
         expect_word(1, 9'h41, 1'b1, 1'b0);
      join
      tick(10);
      expq.push_back(model(1, 9'h7F, 1'b1, 1'b1, 1'b1));
      fork
         send(1, 9'h7F, 1'b1, 1'b1, 1'b1);
         expect_word(1, 9'h7F, 1'b0, 1'b0);
      join
      tick(10);

      // 8N2: second stop bit low, then a clean frame
      expq.push_back(model(2, 9'h3C, 1'b0, 1'b1, 1'b0));
      fork
         send(2, 9'h3C, 1'b0, 1'b1, 1'b0);
         expect_word(2, 9'h3C, 1'b0, 1'b1);
      join
      tick(10);
      expq.push_back(model(2, 9'hC3, 1'b0, 1'b1, 1'b1));
      fork
         send(2, 9'hC3, 1'b0, 1'b1, 1'b1);
         expect_word(2, 9'hC3, 1'b0, 1'b0);
      join
      tick(10);

      // Glitch: 4-cycle low pulse must be rejected
      rx_a[0] = 1'b0;
      tick(4);
      rx_a[0] = 1'b1;
      ok = 0;
      for (int i = 0; i < 10 && ok == 0; i++) begin
         @(negedge clk);
         if (!bz_a[0]) ok = 1;
      end
      chk("glitch_busy_clears", ok, 1);
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (v_a[0]) ok = 1;
      end
      chk("glitch_no_word", ok, 0);

      // Overrun: ready low, 0x11 then 0x22 back to back
      tick(1);
      rdy_a[0] = 1'b0;
      chk("overrun_clear_before", ov_a[0], 0);
      expq.push_back(model(0, 9'h11, 1'b0, 1'b1, 1'b1));
      send(0, 9'h11, 1'b0, 1'b1, 1'b1);
      send(0, 9'h22, 1'b0, 1'b1, 1'b1);
      tick(5);
      chk("overrun_held_word", {v_a[0], dout_x(0)}, {1'b1, 9'h11});
      chk("overrun_set", ov_a[0], 1);
      rdy_a[0] = 1'b1;
      tick(3);
      chk("overrun_after_accept", {v_a[0], ov_a[0]}, {1'b0, 1'b1});

      // Enable dropped mid-DATA, then 0x5A
      rx_a[0] = 1'b0;
      tick(CPB * 3);
      chk("busy_mid_frame", bz_a[0], 1);
      en = 1'b0;
      tick(2);
      chk("enable_abort_idle", bz_a[0], 0);
      rx_a[0] = 1'b1;
      tick(3);
      en = 1'b1;
      tick(20);
      expq.push_back(model(0, 9'h5A, 1'b0, 1'b1, 1'b1));
      fork
         send(0, 9'h5A, 1'b0, 1'b1, 1'b1);
         expect_word(0, 9'h5A, 1'b0, 1'b0);
      join
      tick(20);
      chk("queue_drained", expq.size(), 0);

      // Reset mid-frame with a held word and sticky overrun
      rdy_a[0] = 1'b0;
      expq.push_back(model(0, 9'h33, 1'b0, 1'b1, 1'b1));
      send(0, 9'h33, 1'b0, 1'b1, 1'b1);
      tick(5);
      rx_a[0] = 1'b0;
      tick(30);
      chk("pre_reset_state", {v_a[0], ov_a[0], bz_a[0]}, 3'b111);
      rst = 1'b1;
      rx_a[0] = 1'b1;
      tick(1);
      chk("reset_mid_frame_u0", {dout_x(0), v_a[0], pe_a[0], fe_a[0], ov_a[0], bz_a[0]}, 0);
      expq.delete();
      tick(2);
      rst = 1'b0;
      rdy_a[0] = 1'b1;
      tick(40);
      chk("idle_after_reset", {v_a[0], bz_a[0], ov_a[0]}, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1085, rxclk cycles per serial bit (legal range 16..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-003 SHALL have parameter PARITY_MODE, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked (legal 1 or 2).
REQ-005 SHALL have port rxclk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rxrst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port rxclken  input  1  receive enable; low aborts any frame.
REQ-008 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port dout  output  DATA_BITS  received word, LSB first on the line.
REQ-010 SHALL have port dout_valid  output  1  dout and error flags valid.
REQ-011 SHALL have port dout_ready  input  1  consumer accepts word when high with dout_valid.
REQ-012 SHALL have port parity_err  output  1  parity mismatch on the held word (0 when PARITY_MODE=0).
REQ-013 SHALL have port frame_err  output  1  a stop bit sampled low on the held word.
REQ-014 SHALL have port overrun  output  1  sticky; at least one frame dropped because output was full.
REQ-015 SHALL have port rx_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer; all sampling uses the synchronized signal (2-cycle input latency).
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY_MODE=0.
REQ-018 IDLE: with rxclken high, synchronized rx low SHALL load counter 0 and move to START.
REQ-019 START: at counter == (CLKS_PER_BIT-1)/2 SHALL take a 3-sample majority (counter-1, counter, counter+1); majority 0 -> DATA with counter 0, majority 1 -> IDLE (glitch rejected, no output).
REQ-020 Each later bit SHALL be sampled by 3-sample majority centred exactly CLKS_PER_BIT cycles after the previous centre.
REQ-021 DATA SHALL write sample to dout shift position bitpos, bitpos 0..DATA_BITS-1, then go to PARITY or STOP.
REQ-022 PARITY SHALL compare sample with XOR of data bits (even) or its inverse (odd).
REQ-023 STOP SHALL sample STOP_BITS stop bits; any low sample sets frame error for this frame.
REQ-024 After the final stop-bit centre SHALL return to IDLE immediately, enabling back-to-back frames without gap.
REQ-025 Word, parity_err and frame_err SHALL update and dout_valid rise one cycle after the final stop-bit centre.
REQ-026 dout_valid SHALL stay high with dout/flags stable until a cycle with dout_valid & dout_ready; it drops the next cycle unless a new word completes that same cycle, in which case the new word loads and dout_valid stays high.
REQ-027 A frame completing while dout_valid high and dout_ready low SHALL be dropped, held word kept, overrun set.
REQ-028 overrun SHALL clear only on rxrst.
REQ-029 rxclken low in any non-IDLE state SHALL force IDLE, clear counter and bitpos, produce no word; held output untouched.
REQ-030 Counter SHALL be $clog2(CLKS_PER_BIT)+1 bits and never wrap within a bit period.

Reset
REQ-031 rxrst SHALL force IDLE, counter 0, bitpos 0, synchronizer flops 1, dout 0, dout_valid 0, parity_err 0, frame_err 0, overrun 0, rx_busy 0.
REQ-032 rxrst mid-frame SHALL discard the partial frame; rxrst dominates rxclken and dout_ready.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state enum and PARITY_NONE/EVEN/ODD constants.
REQ-034 Synchronizer plus 3-tap majority SHALL be sub-module uart_rx_sampler; FSM and output register stay in uart_rx_param.

Verification (CLKS_PER_BIT=16 unless noted)
REQ-035 8N1, byte 0xA5, dout_ready high -> dout=0xA5, one-cycle dout_valid, no flags.
REQ-036 DATA_BITS=7, PARITY_MODE=1, byte 0x41 with wrong parity bit 1 -> dout=0x41, parity_err=1.
REQ-037 STOP_BITS=2, second stop bit driven low -> frame_err=1, word still delivered.
REQ-038 rx low for 4 cycles then high -> no dout_valid, rx_busy returns 0 within 10 cycles.
REQ-039 dout_ready low, frames 0x11 then 0x22 -> dout=0x11 held, overrun=1; raising dout_ready then accepts 0x11 and overrun stays 1.
REQ-040 rxclken dropped mid-DATA, then 0x5A sent -> only 0x5A delivered; rxrst mid-frame -> all outputs 0 next cycle.
